// File: rtl/lf_motor_sequencer.sv
// Line-follower motor sequencer: turns thresholded sensor samples into a
// debounced steering state and ramped, dead-timed motor drive commands.
module lf_motor_sequencer #(
  parameter logic [11:0] THRESH     = 12'd1000,
  parameter logic [3:0]  DC_FAST    = 4'd12,
  parameter logic [3:0]  DC_SLOW    = 4'd6,
  parameter logic [3:0]  RAMP_STEP  = 4'd2,
  parameter logic [1:0]  DEBOUNCE   = 2'd2,
  parameter logic [3:0]  NODE_HOLD  = 4'd4,
  parameter logic [5:0]  LOST_LIMIT = 6'd20
) (
  input  logic        clk_3125KHz,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [11:0] left_value,
  input  logic [11:0] center_value,
  input  logic [11:0] right_value,
  output logic        m1_a,
  output logic        m1_b,
  output logic        m2_a,
  output logic        m2_b,
  output logic [3:0]  dc1,
  output logic [3:0]  dc2,
  output logic        node_pulse,
  output logic [3:0]  node_count,
  output logic        lost,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FOLLOW = 3'd1;
  localparam logic [2:0] S_CORR_L = 3'd2;
  localparam logic [2:0] S_CORR_R = 3'd3;
  localparam logic [2:0] S_NODE   = 3'd4;
  localparam logic [2:0] S_LOST   = 3'd5;

  // Direction pairs are {a,b}
  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;

  localparam logic [1:0] LAST_NONE = 2'd0;
  localparam logic [1:0] LAST_L    = 2'd1;
  localparam logic [1:0] LAST_R    = 2'd2;

  logic [2:0] r_state;
  logic [3:0] r_dc1, r_dc2;
  logic [1:0] r_dir1, r_dir2;
  logic       r_node_pulse;
  logic [3:0] r_node_count;
  logic       r_lost;
  logic [1:0] r_last;
  logic [2:0] r_last_p;
  logic [1:0] r_db_cnt;
  logic [3:0] r_hold_cnt;
  logic [5:0] r_lost_cnt;

  logic [2:0] w_p;
  logic [1:0] w_db_cnt_next;
  logic       w_debounced;
  logic [2:0] w_steer;
  logic [2:0] w_state_next;
  logic       w_lost_timeout;
  logic [1:0] w_tdir1, w_tdir2;
  logic [3:0] w_tdc1, w_tdc2;

  assign w_p = {left_value >= THRESH, center_value >= THRESH, right_value >= THRESH};

  // Move a duty value toward its target by at most one ramp step
  function automatic logic [3:0] f_toward(input logic [3:0] cur, input logic [3:0] tgt);
    if (cur < tgt) return ((tgt - cur) > RAMP_STEP) ? cur + RAMP_STEP : tgt;
    else           return ((cur - tgt) > RAMP_STEP) ? cur - RAMP_STEP : tgt;
  endfunction

  // One motor update {dir,dc}: a direction change first ramps to zero and
  // coasts, and only switches direction once the duty is already zero
  function automatic logic [5:0] f_motor(input logic [1:0] dir, input logic [3:0] dc,
                                         input logic [1:0] tdir, input logic [3:0] tdc);
    if (dir == tdir)          return {dir, f_toward(dc, tdc)};
    else if (dc == 4'd0)      return {tdir, f_toward(4'd0, tdc)};
    else if (dc <= RAMP_STEP) return {DIR_COAST, 4'd0};
    else                      return {dir, dc - RAMP_STEP};
  endfunction

  // Debounce count for the current sample and the steering decision it implies
  always_comb begin
    if (r_db_cnt == 2'd0 || w_p != r_last_p) w_db_cnt_next = 2'd1;
    else if (r_db_cnt == 2'd3)               w_db_cnt_next = 2'd3;
    else                                     w_db_cnt_next = r_db_cnt + 2'd1;
    w_debounced = (w_db_cnt_next >= DEBOUNCE);
    case (w_p)
      3'b010:         w_steer = S_FOLLOW;
      3'b110, 3'b100: w_steer = S_CORR_L;
      3'b011, 3'b001: w_steer = S_CORR_R;
      3'b111:         w_steer = S_NODE;
      3'b000:         w_steer = S_LOST;
      default:        w_steer = r_state;
    endcase
  end

  // Drive target (direction and duty) for each motor in the current state
  always_comb begin
    w_tdir1 = DIR_COAST;
    w_tdir2 = DIR_COAST;
    w_tdc1  = 4'd0;
    w_tdc2  = 4'd0;
    case (r_state)
      S_FOLLOW: begin w_tdir1 = DIR_FWD; w_tdir2 = DIR_FWD; w_tdc1 = DC_FAST; w_tdc2 = DC_FAST; end
      S_CORR_L: begin w_tdir1 = DIR_FWD; w_tdir2 = DIR_FWD; w_tdc1 = DC_SLOW; w_tdc2 = DC_FAST; end
      S_CORR_R: begin w_tdir1 = DIR_FWD; w_tdir2 = DIR_FWD; w_tdc1 = DC_FAST; w_tdc2 = DC_SLOW; end
      S_NODE:   begin w_tdir1 = DIR_FWD; w_tdir2 = DIR_FWD; w_tdc1 = DC_SLOW; w_tdc2 = DC_SLOW; end
      S_LOST: begin
        // Pivot back toward the side the line was last seen on
        w_tdir1 = (r_last == LAST_L) ? DIR_REV : DIR_FWD;
        w_tdir2 = (r_last == LAST_L) ? DIR_FWD : DIR_REV;
        w_tdc1  = DC_SLOW;
        w_tdc2  = DC_SLOW;
      end
      default: ;
    endcase
  end

  // Next state on an accepted sample
  always_comb begin
    w_state_next   = r_state;
    w_lost_timeout = 1'b0;
    case (r_state)
      S_IDLE: w_state_next = r_lost ? S_IDLE : S_FOLLOW;
      S_FOLLOW, S_CORR_L, S_CORR_R:
        if (w_debounced) w_state_next = w_steer;
      S_NODE:
        if (({1'b0, r_hold_cnt} + 5'd1) >= {1'b0, NODE_HOLD}) w_state_next = S_FOLLOW;
      S_LOST:
        if (w_p == 3'b000) begin
          if (({1'b0, r_lost_cnt} + 7'd1) >= {1'b0, LOST_LIMIT}) begin
            w_state_next   = S_IDLE;
            w_lost_timeout = 1'b1;
          end
        end else if (w_debounced) begin
          w_state_next = w_steer;
        end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, counters and ramped drive registers
  always_ff @(posedge clk_3125KHz) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_dc1        <= 4'd0;
      r_dc2        <= 4'd0;
      r_dir1       <= DIR_COAST;
      r_dir2       <= DIR_COAST;
      r_node_pulse <= 1'b0;
      r_node_count <= 4'd0;
      r_lost       <= 1'b0;
      r_last       <= LAST_NONE;
      r_last_p     <= 3'd0;
      r_db_cnt     <= 2'd0;
      r_hold_cnt   <= 4'd0;
      r_lost_cnt   <= 6'd0;
    end else begin
      r_node_pulse <= 1'b0;
      if (!enable || r_state > S_LOST) begin
        // Run request dropped (or illegal code): stop immediately, discard sample
        r_state    <= S_IDLE;
        r_dc1      <= 4'd0;
        r_dc2      <= 4'd0;
        r_dir1     <= DIR_COAST;
        r_dir2     <= DIR_COAST;
        r_db_cnt   <= 2'd0;
        r_hold_cnt <= 4'd0;
        r_lost_cnt <= 6'd0;
      end else if (sample_valid) begin
        r_last_p <= w_p;
        r_db_cnt <= w_db_cnt_next;
        r_state  <= w_state_next;
        if (w_state_next == S_IDLE || r_state == S_IDLE) begin
          r_dc1  <= 4'd0;
          r_dc2  <= 4'd0;
          r_dir1 <= DIR_COAST;
          r_dir2 <= DIR_COAST;
        end else begin
          {r_dir1, r_dc1} <= f_motor(r_dir1, r_dc1, w_tdir1, w_tdc1);
          {r_dir2, r_dc2} <= f_motor(r_dir2, r_dc2, w_tdir2, w_tdc2);
        end
        if (w_state_next == S_NODE && r_state != S_NODE) begin
          r_node_pulse <= 1'b1;
          r_hold_cnt   <= 4'd0;
          if (r_node_count != 4'd15) r_node_count <= r_node_count + 4'd1;
        end else if (r_state == S_NODE) begin
          r_hold_cnt <= r_hold_cnt + 4'd1;
        end
        if (w_state_next == S_LOST && r_state != S_LOST) r_lost_cnt <= 6'd0;
        else if (r_state == S_LOST) r_lost_cnt <= (w_p == 3'b000) ? r_lost_cnt + 6'd1 : 6'd0;
        if (w_lost_timeout) r_lost <= 1'b1;
        if (w_state_next == S_CORR_L) r_last <= LAST_L;
        else if (w_state_next == S_CORR_R) r_last <= LAST_R;
      end
    end
  end

  assign m1_a       = r_dir1[1];
  assign m1_b       = r_dir1[0];
  assign m2_a       = r_dir2[1];
  assign m2_b       = r_dir2[0];
  assign dc1        = r_dc1;
  assign dc2        = r_dc2;
  assign node_pulse = r_node_pulse;
  assign node_count = r_node_count;
  assign lost       = r_lost;
  assign state      = r_state;

endmodule

// File: tb/tb_lf_motor_sequencer.sv
// Bench for lf_motor_sequencer: directed scenarios plus randomized traffic
// checked against a sample-level behavioural model.
`timescale 1ns/1ps
module tb_lf_motor_sequencer;

  logic        clk = 1'b0;
  logic        rst, enable, sample_valid;
  logic [11:0] left_value, center_value, right_value;
  logic        m1_a, m1_b, m2_a, m2_b;
  logic [3:0]  dc1, dc2, node_count;
  logic        node_pulse, lost;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  lf_motor_sequencer dut (
    .clk_3125KHz(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .left_value(left_value), .center_value(center_value), .right_value(right_value),
    .m1_a(m1_a), .m1_b(m1_b), .m2_a(m2_a), .m2_b(m2_b),
    .dc1(dc1), .dc2(dc2), .node_pulse(node_pulse), .node_count(node_count),
    .lost(lost), .state(state)
  );

  always #160 clk = ~clk;

  // Behavioural model: states 0..5, directions 2 = forward, 1 = reverse, 0 = coast
  int m_state, m_dc1, m_dc2, m_dir1, m_dir2, m_pulse, m_ncount, m_lost, m_last, m_since;
  int hist[$];

  function automatic int decide(input int p, input int cur);
    case (p)
      2: return 1;
      6, 4: return 2;
      3, 1: return 3;
      7: return 4;
      0: return 5;
      default: return cur;
    endcase
  endfunction

  function automatic int motor(input int dir, input int dc, input int tdir, input int tdc);
    int delta;
    if (dir != tdir && dc != 0) begin
      dc = (dc > 2) ? dc - 2 : 0;
      if (dc == 0) dir = 0;
      return dir * 16 + dc;
    end
    delta = tdc - dc;
    if (delta > 2)  delta = 2;
    if (delta < -2) delta = -2;
    return tdir * 16 + dc + delta;
  endfunction

  task automatic model_zero_drive();
    m_dc1 = 0; m_dc2 = 0; m_dir1 = 0; m_dir2 = 0;
  endtask

  task automatic model_step(input bit r, input bit e, input bit v, input int l, input int c, input int rr);
    int p, run, ns, t1, t2, d1, d2, mv, zr;
    bit deb;
    m_pulse = 0;
    if (r) begin
      m_state = 0; model_zero_drive(); m_ncount = 0; m_lost = 0; m_last = 0; m_since = 0;
      hist.delete();
    end else if (!e) begin
      m_state = 0; model_zero_drive(); m_since = 0;
      hist.delete();
    end else if (v) begin
      p = (l >= 1000 ? 4 : 0) + (c >= 1000 ? 2 : 0) + (rr >= 1000 ? 1 : 0);
      hist.push_back(p);
      if (hist.size() > 64) void'(hist.pop_front());
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i] != p) break;
        run++;
      end
      deb = (run >= 2);
      m_since++;
      ns = m_state;
      if (m_state == 0) begin
        if (m_lost == 0) ns = 1;
      end else if (m_state == 4) begin
        if (m_since >= 4) ns = 1;
      end else if (m_state == 5 && p == 0) begin
        zr = (run < m_since) ? run : m_since;
        if (zr >= 20) begin ns = 0; m_lost = 1; end
      end else if (deb) begin
        ns = decide(p, m_state);
      end
      if (m_state != 0) begin
        t1 = 2; t2 = 2; d1 = 6; d2 = 6;
        case (m_state)
          1: begin d1 = 12; d2 = 12; end
          2: d2 = 12;
          3: d1 = 12;
          5: if (m_last == 1) t1 = 1; else t2 = 1;
          default: ;
        endcase
        mv = motor(m_dir1, m_dc1, t1, d1); m_dir1 = mv / 16; m_dc1 = mv % 16;
        mv = motor(m_dir2, m_dc2, t2, d2); m_dir2 = mv / 16; m_dc2 = mv % 16;
      end
      if (ns == 4 && m_state != 4) begin
        m_pulse = 1;
        if (m_ncount < 15) m_ncount++;
      end
      if (ns == 2) m_last = 1;
      if (ns == 3) m_last = 2;
      if (ns != m_state) m_since = 0;
      if (ns == 0) model_zero_drive();
      m_state = ns;
    end
  endtask

  function automatic logic [20:0] dut_vec();
    return {state, dc1, dc2, m1_a, m1_b, m2_a, m2_b, node_pulse, node_count, lost};
  endfunction

  function automatic logic [20:0] mdl_vec();
    return {3'(m_state), 4'(m_dc1), 4'(m_dc2), 2'(m_dir1), 2'(m_dir2), 1'(m_pulse), 4'(m_ncount), 1'(m_lost)};
  endfunction

  // ADC value on either side of the threshold, including the exact boundary
  function automatic int adc(input bit b);
    int k;
    k = $urandom_range(0, 2);
    if (b) return (k == 0) ? 1000 : (k == 1) ? $urandom_range(1001, 4095) : 4095;
    else   return (k == 0) ? 999 : (k == 1) ? 0 : $urandom_range(0, 998);
  endfunction

  task automatic drive(input bit r, input bit e, input bit v, input int l, input int c, input int rr);
    @(negedge clk);
    rst = r; enable = e; sample_valid = v;
    left_value = 12'(l); center_value = 12'(c); right_value = 12'(rr);
    model_step(r, e, v, l, c, rr);
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d rst=%0b en=%0b sv=%0b L=%0d C=%0d R=%0d -> state=%0d dc=%0d/%0d dir=%0b%0b/%0b%0b node=%0d lost=%0b",
             txn, r, e, v, l, c, rr, state, dc1, dc2, m1_a, m1_b, m2_a, m2_b, node_count, lost);
  endtask

  task automatic drive_p(input bit r, input bit e, input bit v, input int p);
    drive(r, e, v, adc(p[2]), adc(p[1]), adc(p[0]));
  endtask

  task automatic test_reset();
    drive_p(1, 0, 0, 0);
    drive_p(1, 1, 1, 7);
    checks++;
    if (dut_vec() !== 21'd0) begin
      errors++; $display("FAIL reset_state: got %h expected %h", dut_vec(), 21'd0);
    end
    drive_p(0, 0, 0, 0);
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL reset_idle: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_follow_ramp();
    int exp_dc[7] = '{2, 4, 6, 8, 10, 12, 12};
    drive(0, 1, 1, 100, 2000, 100);
    checks++;
    if (state !== 3'd1 || dc1 !== 4'd0 || dc2 !== 4'd0) begin
      errors++; $display("FAIL follow_entry: got state=%0d dc=%0d/%0d expected state=1 dc=0/0", state, dc1, dc2);
    end
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 0, 100, 2000, 100);
      drive(0, 1, 1, 100, 2000, 100);
      checks++;
      if (dc1 !== 4'(exp_dc[i]) || dc2 !== 4'(exp_dc[i]) || {m1_a, m1_b, m2_a, m2_b} !== 4'b1010 || state !== 3'd1) begin
        errors++;
        $display("FAIL follow_ramp[%0d]: got dc=%0d/%0d dir=%0b%0b%0b%0b state=%0d expected dc=%0d/%0d dir=1010 state=1",
                 i, dc1, dc2, m1_a, m1_b, m2_a, m2_b, state, exp_dc[i], exp_dc[i]);
      end
    end
  endtask

  task automatic test_corr();
    int pats[3] = '{2, 6, 2};
    int exp1[3] = '{10, 8, 6};
    for (int i = 0; i < 3; i++) begin
      drive_p(0, 1, 1, pats[i]);
      checks++;
      if (state !== 3'd1) begin
        errors++; $display("FAIL corr_glitch[%0d]: got state=%0d expected 1", i, state);
      end
    end
    drive_p(0, 1, 1, 6);
    drive_p(0, 1, 1, 6);
    checks++;
    if (state !== 3'd2 || dc1 !== 4'd12) begin
      errors++; $display("FAIL corr_enter: got state=%0d dc1=%0d expected state=2 dc1=12", state, dc1);
    end
    for (int i = 0; i < 3; i++) begin
      drive_p(0, 1, 1, 6);
      checks++;
      if (dc1 !== 4'(exp1[i]) || dc2 !== 4'd12) begin
        errors++; $display("FAIL corr_ramp[%0d]: got dc=%0d/%0d expected %0d/12", i, dc1, dc2, exp1[i]);
      end
    end
  endtask

  task automatic test_lost();
    int exp1[6]  = '{4, 2, 0, 2, 4, 6};
    int exp2[6]  = '{10, 8, 6, 6, 6, 6};
    int expd1[6] = '{2, 2, 0, 1, 1, 1};
    drive_p(0, 1, 1, 0);
    drive_p(0, 1, 1, 0);
    checks++;
    if (state !== 3'd5) begin
      errors++; $display("FAIL lost_enter: got state=%0d expected 5", state);
    end
    for (int i = 0; i < 20; i++) begin
      drive_p(0, 1, 1, 0);
      if (i < 6) begin
        checks++;
        if (dc1 !== 4'(exp1[i]) || dc2 !== 4'(exp2[i]) || {m1_a, m1_b} !== 2'(expd1[i]) || {m2_a, m2_b} !== 2'b10) begin
          errors++;
          $display("FAIL lost_pivot[%0d]: got dc=%0d/%0d dir=%0b%0b/%0b%0b expected dc=%0d/%0d m1=%0d m2=10",
                   i, dc1, dc2, m1_a, m1_b, m2_a, m2_b, exp1[i], exp2[i], expd1[i]);
        end
      end
      if (i == 18) begin
        checks++;
        if (state !== 3'd5 || lost !== 1'b0) begin
          errors++; $display("FAIL lost_early: got state=%0d lost=%0b expected 5/0", state, lost);
        end
      end
    end
    checks++;
    if (state !== 3'd0 || lost !== 1'b1 || dc1 !== 4'd0 || dc2 !== 4'd0 || {m1_a, m1_b, m2_a, m2_b} !== 4'b0000) begin
      errors++; $display("FAIL lost_timeout: got state=%0d lost=%0b dc=%0d/%0d expected 0/1 dc 0/0", state, lost, dc1, dc2);
    end
    drive_p(0, 0, 0, 2);
    for (int i = 0; i < 3; i++) drive_p(0, 1, 1, 2);
    checks++;
    if (state !== 3'd0 || lost !== 1'b1 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL lost_sticky: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_enable_drop();
    drive_p(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive_p(0, 1, 1, 2);
    checks++;
    if (dc1 !== 4'd8 || dc2 !== 4'd8) begin
      errors++; $display("FAIL drop_setup: got dc=%0d/%0d expected 8/8", dc1, dc2);
    end
    drive_p(0, 0, 1, 7);
    checks++;
    if (dut_vec() !== 21'd0) begin
      errors++; $display("FAIL drop_idle: got %h expected %h", dut_vec(), 21'd0);
    end
    drive_p(0, 1, 1, 2);
    checks++;
    if (state !== 3'd1 || dc1 !== 4'd0 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL drop_restart: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_node();
    int expc;
    drive_p(1, 0, 0, 0);
    drive_p(0, 1, 1, 2);
    drive_p(0, 1, 1, 2);
    for (int k = 1; k <= 17; k++) begin
      drive_p(0, 1, 1, 7);
      drive_p(0, 1, 1, 7);
      expc = (k > 15) ? 15 : k;
      checks++;
      if (state !== 3'd4 || node_pulse !== 1'b1 || node_count !== 4'(expc)) begin
        errors++; $display("FAIL node_enter[%0d]: got state=%0d pulse=%0b count=%0d expected 4/1/%0d",
                           k, state, node_pulse, node_count, expc);
      end
      drive_p(0, 1, 0, 2);
      checks++;
      if (node_pulse !== 1'b0) begin
        errors++; $display("FAIL node_pulse_width[%0d]: got %0b expected 0", k, node_pulse);
      end
      for (int i = 0; i < 4; i++) drive_p(0, 1, 1, (i == 0) ? 7 : 2);
      checks++;
      if (state !== 3'd1 || dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL node_exit[%0d]: got %h expected %h", k, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_p(1, 0, 0, 0);
    drive_p(0, 1, 1, 2);
    for (int k = 0; k < 3; k++) begin
      drive_p(0, 1, 1, 7);
      drive_p(0, 1, 1, 7);
      if (k < 2) for (int i = 0; i < 4; i++) drive_p(0, 1, 1, 2);
    end
    checks++;
    if (state !== 3'd4 || node_count !== 4'd3) begin
      errors++; $display("FAIL rstmid_setup: got state=%0d count=%0d expected 4/3", state, node_count);
    end
    drive_p(1, 1, 1, 7);
    checks++;
    if (dut_vec() !== 21'd0) begin
      errors++; $display("FAIL rstmid_clear: got %h expected %h", dut_vec(), 21'd0);
    end
  endtask

  task automatic test_random();
    int cur_p = 2;
    int bad = 0;
    bit r, e, v;
    drive_p(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 59) != 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) cur_p = $urandom_range(0, 7);
      drive_p(r, e, v, cur_p);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        if (bad < 10) $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), mdl_vec());
        bad++;
      end
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; sample_valid = 1'b0;
    left_value = '0; center_value = '0; right_value = '0;
    m_state = 0; m_dc1 = 0; m_dc2 = 0; m_dir1 = 0; m_dir2 = 0;
    m_pulse = 0; m_ncount = 0; m_lost = 0; m_last = 0; m_since = 0;
    test_reset();
    test_follow_ramp();
    test_corr();
    test_lost();
    test_enable_drop();
    test_node();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
